// File: rtl/operand_register_file_pkg.sv
// ============================================================================
// Module  : operand_register_file_pkg
// Brief   : Shared widths and encodings for the operand register file.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package operand_register_file_pkg;

    localparam int c_data_w = 16;

    // FunSel operation encodings
    localparam logic [2:0] c_fun_dec        = 3'b000;
    localparam logic [2:0] c_fun_inc        = 3'b001;
    localparam logic [2:0] c_fun_load       = 3'b010;
    localparam logic [2:0] c_fun_clr        = 3'b011;
    localparam logic [2:0] c_fun_loadl_clrh = 3'b100;
    localparam logic [2:0] c_fun_loadl      = 3'b101;
    localparam logic [2:0] c_fun_loadh      = 3'b110;
    localparam logic [2:0] c_fun_sext       = 3'b111;

    // OutASel / OutBSel source encodings
    localparam logic [2:0] c_sel_r1 = 3'd0;
    localparam logic [2:0] c_sel_r2 = 3'd1;
    localparam logic [2:0] c_sel_r3 = 3'd2;
    localparam logic [2:0] c_sel_r4 = 3'd3;
    localparam logic [2:0] c_sel_s1 = 3'd4;
    localparam logic [2:0] c_sel_s2 = 3'd5;
    localparam logic [2:0] c_sel_s3 = 3'd6;
    localparam logic [2:0] c_sel_s4 = 3'd7;

    localparam int c_num_gen = 4;
    localparam int c_num_scr = 4;

endpackage

`default_nettype wire

// File: rtl/operand_register_file_register16.sv
// ============================================================================
// Module  : register16
// Brief   : One operand register; applies the FunSel operation when enabled.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module register16
    import operand_register_file_pkg::*;
#(
    parameter int DATA_W = c_data_w
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              enable,
    input  logic [2:0]        FunSel,
    input  logic [DATA_W-1:0] I,
    output logic [DATA_W-1:0] Q
);

    logic [DATA_W-1:0] r_q;
    logic [DATA_W-1:0] w_next;

    // Byte operations use I[7:0]; "high byte" is the top eight bits of the register.
    always_comb begin
        w_next = r_q;
        case (FunSel)
            c_fun_dec:        w_next = r_q - 1'b1;
            c_fun_inc:        w_next = r_q + 1'b1;
            c_fun_load:       w_next = I;
            c_fun_clr:        w_next = '0;
            c_fun_loadl_clrh: w_next = {{(DATA_W-8){1'b0}}, I[7:0]};
            c_fun_loadl:      w_next = {r_q[DATA_W-1:8], I[7:0]};
            c_fun_loadh:      w_next = {I[7:0], r_q[DATA_W-9:0]};
            c_fun_sext:       w_next = {{(DATA_W-8){I[7]}}, I[7:0]};
            default:          w_next = r_q;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_q <= '0;
        end else if (enable) begin
            r_q <= w_next;
        end
    end

    assign Q = r_q;

endmodule

`default_nettype wire

// File: rtl/operand_register_file.sv
// ============================================================================
// Module  : operand_register_file
// Brief   : R1..R4 plus optional S1..S4 (ORF_SCRATCH_REGS_EN) with two
//           zero-latency operand read ports.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_register_file
    import operand_register_file_pkg::*;
#(
    parameter int DATA_W = c_data_w
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [DATA_W-1:0] I,
    input  logic [2:0]        FunSel,
    input  logic [3:0]        RegSel,
    input  logic [3:0]        ScrSel,
    input  logic [2:0]        OutASel,
    input  logic [2:0]        OutBSel,
    output logic [DATA_W-1:0] OutA,
    output logic [DATA_W-1:0] OutB
);

    // Slots 0..3 hold R1..R4, slots 4..7 hold S1..S4 (or constant zero).
    logic [DATA_W-1:0] w_q [0:7];

    for (genvar gi = 0; gi < c_num_gen; gi++) begin : g_gen_reg
        register16 #(.DATA_W(DATA_W)) u_reg (
            .Clock  (Clock),
            .Reset  (Reset),
            .enable (RegSel[gi]),
            .FunSel (FunSel),
            .I      (I),
            .Q      (w_q[gi])
        );
    end

`ifdef ORF_SCRATCH_REGS_EN
    for (genvar gi = 0; gi < c_num_scr; gi++) begin : g_scr_reg
        register16 #(.DATA_W(DATA_W)) u_reg (
            .Clock  (Clock),
            .Reset  (Reset),
            .enable (ScrSel[gi]),
            .FunSel (FunSel),
            .I      (I),
            .Q      (w_q[c_num_gen + gi])
        );
    end
`else
    for (genvar gi = 0; gi < c_num_scr; gi++) begin : g_scr_zero
        assign w_q[c_num_gen + gi] = '0;
    end

    logic w_unused_scrsel;
    assign w_unused_scrsel = ^ScrSel;
`endif

    // Reads see current state only; a same-cycle write shows after the edge.
    assign OutA = w_q[OutASel];
    assign OutB = w_q[OutBSel];

endmodule

`default_nettype wire

// File: tb/tb_operand_register_file.sv
// ============================================================================
// Module  : tb_operand_register_file
// Brief   : Directed self-checking bench for operand_register_file; scratch
//           expectations follow ORF_SCRATCH_REGS_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_operand_register_file;

    localparam int DATA_W = 16;

    logic              Clock;
    logic              Reset;
    logic [DATA_W-1:0] I;
    logic [2:0]        FunSel;
    logic [3:0]        RegSel;
    logic [3:0]        ScrSel;
    logic [2:0]        OutASel;
    logic [2:0]        OutBSel;
    logic [DATA_W-1:0] OutA;
    logic [DATA_W-1:0] OutB;

    int n_total = 0;
    int n_bad   = 0;

    operand_register_file #(.DATA_W(DATA_W)) u_dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .I       (I),
        .FunSel  (FunSel),
        .RegSel  (RegSel),
        .ScrSel  (ScrSel),
        .OutASel (OutASel),
        .OutBSel (OutBSel),
        .OutA    (OutA),
        .OutB    (OutB)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

`ifdef ORF_SCRATCH_REGS_EN
    localparam bit c_scr_en = 1'b1;
`else
    localparam bit c_scr_en = 1'b0;
`endif

    task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                         input logic [DATA_W-1:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic drive(input logic [2:0] fs, input logic [3:0] rs,
                         input logic [3:0] ss, input logic [DATA_W-1:0] din);
        FunSel = fs;
        RegSel = rs;
        ScrSel = ss;
        I      = din;
    endtask

    task automatic idle;
        drive(3'b000, 4'b0000, 4'b0000, '0);
    endtask

    task automatic read_a(input logic [2:0] sel);
        OutASel = sel;
        #1;
    endtask

    initial begin
        Reset   = 1'b0;
        OutASel = 3'd0;
        OutBSel = 3'd0;
        idle();
        #1;
        check("reset_outa", OutA, 16'h0000);
        check("reset_outb", OutB, 16'h0000);
        tick();
        tick();
        Reset = 1'b1;

        // Release takes effect on the very next edge
        drive(3'b010, 4'b1111, 4'b1111, 16'h1234);
        tick();
        idle();
        OutASel = 3'd2;
        OutBSel = 3'd3;
        #1;
        check("load_1234_a", OutA, 16'h1234);
        check("load_1234_b", OutB, 16'h1234);

        // Asynchronous reset mid-cycle, no clock edge
        #2;
        Reset = 1'b0;
        #1;
        check("async_rst_a", OutA, 16'h0000);
        check("async_rst_b", OutB, 16'h0000);

        // Reset dominates a concurrent write
        drive(3'b010, 4'b1111, 4'b1111, 16'hBEEF);
        tick();
        check("rst_dominates", OutA, 16'h0000);
        idle();
        Reset = 1'b1;

        // Wrap-around on R1
        drive(3'b011, 4'b0001, 4'b0000, '0);
        tick();
        drive(3'b000, 4'b0001, 4'b0000, '0);
        tick();
        read_a(3'd0);
        check("dec_wrap", OutA, 16'hFFFF);
        drive(3'b001, 4'b0001, 4'b0000, '0);
        tick();
        check("inc_wrap", OutA, 16'h0000);

        // Byte and sign-extend loads on R2
        drive(3'b010, 4'b0010, 4'b0000, 16'hABCD);
        tick();
        read_a(3'd1);
        check("r2_load", OutA, 16'hABCD);
        drive(3'b110, 4'b0010, 4'b0000, 16'h0080);
        tick();
        check("r2_loadh", OutA, 16'h80CD);
        drive(3'b111, 4'b0010, 4'b0000, 16'h0080);
        tick();
        check("r2_sext", OutA, 16'hFF80);
        drive(3'b101, 4'b0010, 4'b0000, 16'h0012);
        tick();
        check("r2_loadl", OutA, 16'hFF12);
        drive(3'b111, 4'b0010, 4'b0000, 16'h0055);
        tick();
        check("r2_sext_pos", OutA, 16'h0055);
        drive(3'b100, 4'b0010, 4'b0000, 16'h3456);
        tick();
        check("r2_loadl_clrh", OutA, 16'h0056);
        read_a(3'd0);
        check("r1_untouched", OutA, 16'h0000);

        // Multi-select load, sweep both read ports
        drive(3'b010, 4'b1111, 4'b1111, 16'h5A5A);
        tick();
        idle();
        for (int s = 0; s < 8; s++) begin
            logic [DATA_W-1:0] exp_v;
            exp_v = (s < 4 || c_scr_en) ? 16'h5A5A : 16'h0000;
            OutASel = 3'(s);
            OutBSel = 3'(7 - s);
            #1;
            check($sformatf("sweep_a%0d", s), OutA, exp_v);
            exp_v = ((7 - s) < 4 || c_scr_en) ? 16'h5A5A : 16'h0000;
            check($sformatf("sweep_b%0d", 7 - s), OutB, exp_v);
        end

        // Both ports on the same register
        drive(3'b010, 4'b0100, 4'b0000, 16'hC3A1);
        tick();
        idle();
        OutASel = 3'd2;
        OutBSel = 3'd2;
        #1;
        check("same_sel_a", OutA, 16'hC3A1);
        check("same_sel_b", OutB, 16'hC3A1);

        // Read/write overlap: old value until the edge
        drive(3'b010, 4'b0001, 4'b0000, 16'h0007);
        tick();
        OutASel = 3'd0;
        drive(3'b001, 4'b0001, 4'b0000, '0);
        #1;
        check("overlap_before", OutA, 16'h0007);
        tick();
        check("overlap_after", OutA, 16'h0008);

        // All enables low is a no-op
        drive(3'b011, 4'b0000, 4'b0000, '0);
        tick();
        check("noop_r1", OutA, 16'h0008);

        // Scratch write with ScrSel only; general registers untouched
        drive(3'b010, 4'b0000, 4'b1111, 16'hFFFF);
        OutBSel = 3'd5;
        tick();
        idle();
        check("scr_outb5", OutB, c_scr_en ? 16'hFFFF : 16'h0000);
        read_a(3'd1);
        check("scr_r2_hold", OutA, 16'h5A5A);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/operand_register_file.md
OPERAND_REGISTER_FILE -- requirements
Module: operand_register_file

Interface
REQ-001 Parameter: DATA_W, default 16, register and port data width in bits.
REQ-002 Clock  input  1  rising-edge clock for all state.
REQ-003 Reset  input  1  asynchronous, active-low reset; 0 clears all registers immediately.
REQ-004 I  input  DATA_W  write data for load operations.
REQ-005 FunSel  input  3  register operation, applied to every selected register.
REQ-006 RegSel  input  4  active-high write enables, bit0..bit3 = R1..R4.
REQ-007 ScrSel  input  4  active-high write enables, bit0..bit3 = S1..S4.
REQ-008 OutASel  input  3  operand A source: 0..3 = R1..R4, 4..7 = S1..S4.
REQ-009 OutBSel  input  3  operand B source, same encoding as OutASel.
REQ-010 OutA  output  DATA_W  operand A, drives the ALU A input.
REQ-011 OutB  output  DATA_W  operand B, drives the ALU B input.

Function
REQ-012 The block SHALL hold eight DATA_W registers: R1..R4 (general) and S1..S4 (scratch).
REQ-013 On each rising Clock edge, every register with its enable bit set SHALL update per FunSel; unselected registers hold.
REQ-014 FunSel 000 SHALL decrement by 1, wrapping 0x0000 -> 0xFFFF.
REQ-015 FunSel 001 SHALL increment by 1, wrapping 0xFFFF -> 0x0000.
REQ-016 FunSel 010 SHALL load I in full.
REQ-017 FunSel 011 SHALL clear to 0.
REQ-018 FunSel 100 SHALL load {8'h00, I[7:0]} (clear high byte, load low byte).
REQ-019 FunSel 101 SHALL load I[7:0] into the low byte only and keep the high byte.
REQ-020 FunSel 110 SHALL load I[7:0] into the high byte only and keep the low byte.
REQ-021 FunSel 111 SHALL load I[7:0] sign-extended to DATA_W.
REQ-022 Multiple enable bits set SHALL apply the same operation independently to each selected register.
REQ-023 All enables 0 SHALL be a no-op for any FunSel.
REQ-024 OutA and OutB SHALL be combinational muxes of current register state: zero-latency read; a write becomes visible the cycle after the edge. There is no write-to-read bypass.
REQ-025 OutASel equal to OutBSel SHALL present the same register on both outputs.
REQ-026 Read and write of the same register in one cycle SHALL output the old value until the edge.

Reset
REQ-027 Reset low SHALL asynchronously force all eight registers to 0, so OutA and OutB become 0 without a clock edge.
REQ-028 Reset SHALL dominate any in-progress write in that cycle.
REQ-029 Reset deassertion SHALL take effect at the next rising Clock edge with no extra wait cycles.

Configuration
REQ-030 Macro ORF_SCRATCH_REGS_EN defined: S1..S4 are implemented as in REQ-012..REQ-026.
REQ-031 Macro ORF_SCRATCH_REGS_EN undefined:
- S1..S4 SHALL NOT be instantiated.
- ScrSel SHALL be ignored.
- OutASel/OutBSel values 4..7 SHALL read 0.
- Port list is unchanged.

Structure
REQ-032 A shared package SHALL hold:
- DATA_W default
- FunSel encodings (DEC, INC, LOAD, CLR, LOADL_CLRH, LOADL, LOADH, SEXT)
- OutSel encodings
REQ-033 One sub-module, register16, SHALL implement a single register: Clock, Reset, enable, FunSel, I, Q.
REQ-034 The block SHALL instantiate register16 four or eight times, depending on ORF_SCRATCH_REGS_EN.

Verification
REQ-035 Reset low with all registers 0x1234 -> OutA = OutB = 0 immediately, without a clock edge.
REQ-036 Wrap-around:
- RegSel=0001, FunSel=011, then FunSel=000 -> R1 = 0xFFFF.
- FunSel=001 -> R1 = 0x0000.
REQ-037 Byte and sign-extend loads:
- R2 = 0xABCD, I = 0x0080, FunSel=110 -> R2 = 0x80CD.
- FunSel=111 -> R2 = 0xFF80.
- FunSel=101, I=0x0012 -> R2 = 0xFF12.
REQ-038 Multi-select: RegSel=1111, ScrSel=1111, FunSel=010, I=0x5A5A -> all eight read 0x5A5A via sweeps of OutASel/OutBSel 0..7.
REQ-039 Read/write overlap: OutASel=0, RegSel=0001, FunSel=001, R1=7 -> OutA = 7 before the edge and 8 after it.
REQ-040 With ORF_SCRATCH_REGS_EN undefined: ScrSel=1111, FunSel=010, I=0xFFFF, OutBSel=5 -> OutB = 0.
